// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch to a 1-cycle synchronous memory,
// DEPTH-entry PC/instruction FIFO to the decoder, redirect flush. Optional IFQ_DECODE_EN.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_insn,
`ifdef IFQ_DECODE_EN
  output logic [6:0]                 opcode,
  output logic [4:0]                 rd,
  output logic [2:0]                 funct3,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [6:0]                 funct7,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

`ifdef IFQ_DECODE_EN
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } fields_t;

  fields_t mem_fields [DEPTH];
  fields_t head_fields;
`endif

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;

  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_insn [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] redirect_target;

  // Masking rather than slicing keeps every redirect_pc bit in use.
  assign redirect_target = redirect_pc & ~XLEN'(3);

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    issue     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight};
    if (!rst) begin
      // Credit: queued entries plus the outstanding fetch never exceed DEPTH.
      issue = !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
      push  = inflight && !redirect_valid;
      pop   = out_valid && out_ready;
    end
  end

  assign imem_req_valid = issue;
  assign imem_req_addr  = fetch_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
    end else if (redirect_valid) begin
      // A same-cycle pop has already been handed over; the flush discards the rest.
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the entry storage is deliberately not reset; the head is gated by
  // out_valid, so stale contents can never reach the decoder.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= inflight_pc;
      mem_insn[wr_ptr] <= imem_rsp_data;
`ifdef IFQ_DECODE_EN
      mem_fields[wr_ptr] <= '{funct7: imem_rsp_data[31:25],
                              rs2:    imem_rsp_data[24:20],
                              rs1:    imem_rsp_data[19:15],
                              funct3: imem_rsp_data[14:12],
                              rd:     imem_rsp_data[11:7],
                              opcode: imem_rsp_data[6:0]};
`endif
    end
  end

  assign count     = count_q;
  assign out_valid = !rst && (count_q != '0);
  assign out_pc    = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_insn  = out_valid ? mem_insn[rd_ptr] : '0;

`ifdef IFQ_DECODE_EN
  assign head_fields = out_valid ? mem_fields[rd_ptr] : '0;
  assign opcode      = head_fields.opcode;
  assign rd          = head_fields.rd;
  assign funct3      = head_fields.funct3;
  assign rs1         = head_fields.rs1;
  assign rs2         = head_fields.rs2;
  assign funct7      = head_fields.funct7;
`endif

endmodule
